// File: rtl/ds_setpoint_ramp.sv
// Setpoint slew limiter feeding the delta-sigma modulator: accepts a target code and
// walks the modulator input toward it in bounded steps paced by frame pulses.
//
//   state | meaning
//   INIT  | first cycle out of reset, strobes RESET_CODE into the modulator
//   IDLE  | holding current code, ready for a new target
//   RAMP  | stepping toward the target, one step per (rate+1) frame pulses
module ds_setpoint_ramp #(
    parameter int                BITS       = 5,
    parameter int                STEP       = 1,
    parameter logic [BITS-1:0]   RESET_CODE = {1'b1, {(BITS-1){1'b0}}},
    parameter int                RATE_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITS-1:0]   tgt_data,
    input  logic              tgt_valid,
    output logic              tgt_ready,
    input  logic [RATE_W-1:0] rate,
    input  logic              frame,
    input  logic              abort,
    output logic [BITS-1:0]   data_out,
    output logic              data_out_en,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_RAMP = 2'd2
    } state_t;

    localparam logic [BITS-1:0]   STEP_C = BITS'(STEP);
    localparam logic [RATE_W-1:0] ONE_R  = {{(RATE_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [BITS-1:0]     code_q, code_d;
    logic [BITS-1:0]     target_q, target_d;
    logic [RATE_W-1:0]   rate_q, rate_d;
    logic [RATE_W-1:0]   count_q, count_d;
    logic                strobe_q, strobe_d;
    logic                done_q, done_d;

    logic                up;
    logic [BITS-1:0]     diff;
    logic [BITS-1:0]     delta;
    logic [BITS-1:0]     step_code;

    // Step size is clamped to the remaining distance so the code never overshoots or wraps.
    always_comb begin
        up        = target_q > code_q;
        diff      = up ? (target_q - code_q) : (code_q - target_q);
        delta     = (diff < STEP_C) ? diff : STEP_C;
        step_code = up ? (code_q + delta) : (code_q - delta);
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        target_d = target_q;
        rate_d   = rate_q;
        count_d  = count_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_INIT: begin
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (tgt_valid) begin
                    target_d = tgt_data;
                    rate_d   = rate;
                    count_d  = '0;
                    if (tgt_data == code_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RAMP;
                    end
                end
            end
            S_RAMP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (frame) begin
                    if (count_q == rate_q) begin
                        count_d  = '0;
                        code_d   = step_code;
                        strobe_d = 1'b1;
                        if (step_code == target_q) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        count_d = count_q + ONE_R;
                    end
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_INIT;
            code_q   <= RESET_CODE;
            target_q <= RESET_CODE;
            rate_q   <= '0;
            count_q  <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            target_q <= target_d;
            rate_q   <= rate_d;
            count_q  <= count_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    // INIT strobe is gated by rst so the reset cycles themselves never load the modulator.
    assign data_out_en = strobe_q | ((state_q == S_INIT) & ~rst);
    assign data_out    = code_q;
    assign busy        = (state_q == S_RAMP);
    assign tgt_ready   = (state_q == S_IDLE);
    assign done        = done_q;

endmodule
